// File: rtl/arm_shift_cond_unit_pkg.sv
// Shared constants for the operand-B shift/condition stage.
// Contents: operand and shift-amount widths, shift opcodes, ARM condition
// codes, and the NZCV flag bit positions in flags_in.
package arm_shift_cond_unit_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned COND_W  = 4;
    localparam int unsigned FLAGS_W = 4;

    // Shift type encodings
    localparam logic [OP_W-1:0] SHIFT_LSL = 2'b00;
    localparam logic [OP_W-1:0] SHIFT_LSR = 2'b01;
    localparam logic [OP_W-1:0] SHIFT_ASR = 2'b10;
    localparam logic [OP_W-1:0] SHIFT_ROR = 2'b11;

    // ARM condition field encodings
    localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
    localparam logic [COND_W-1:0] COND_NE = 4'b0001;
    localparam logic [COND_W-1:0] COND_CS = 4'b0010;
    localparam logic [COND_W-1:0] COND_CC = 4'b0011;
    localparam logic [COND_W-1:0] COND_MI = 4'b0100;
    localparam logic [COND_W-1:0] COND_PL = 4'b0101;
    localparam logic [COND_W-1:0] COND_VS = 4'b0110;
    localparam logic [COND_W-1:0] COND_VC = 4'b0111;
    localparam logic [COND_W-1:0] COND_HI = 4'b1000;
    localparam logic [COND_W-1:0] COND_LS = 4'b1001;
    localparam logic [COND_W-1:0] COND_GE = 4'b1010;
    localparam logic [COND_W-1:0] COND_LT = 4'b1011;
    localparam logic [COND_W-1:0] COND_GT = 4'b1100;
    localparam logic [COND_W-1:0] COND_LE = 4'b1101;
    localparam logic [COND_W-1:0] COND_AL = 4'b1110;
    localparam logic [COND_W-1:0] COND_NV = 4'b1111;

    // Bit positions inside flags_in
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage : arm_shift_cond_unit_pkg

// File: rtl/arm_shift_cond_unit_shift_core.sv
// ARM barrel shifter (combinational).
// Ports:
//   i_data      operand to shift
//   i_amount    selected shift amount (0..31)
//   i_opcode    LSL/LSR/ASR/ROR
//   i_use_rs    1 = amount came from a register (zero means "no shift")
//   i_carry     incoming carry, also the RRX fill bit
//   i_exec      condition passed; when low the operand passes through
//   o_data_c    shifted operand
//   o_carry_c   shifter carry-out
module arm_shift_core
    import arm_shift_cond_unit_pkg::*;
(
    input  logic [DATA_W-1:0]  i_data,
    input  logic [SHAMT_W-1:0] i_amount,
    input  logic [OP_W-1:0]    i_opcode,
    input  logic               i_use_rs,
    input  logic               i_carry,
    input  logic               i_exec,
    output logic [DATA_W-1:0]  o_data_c,
    output logic               o_carry_c
);

    // One extra bit on each shifter catches the last bit shifted out,
    // which is exactly the ARM carry-out for amounts 1..31.
    logic [DATA_W:0]        w_lsl;
    logic [DATA_W:0]        w_lsr;
    logic signed [DATA_W:0] w_asr;
    logic [DATA_W-1:0]      w_ror;
    logic                   w_amt_zero;

    assign w_lsl      = {1'b0, i_data} << i_amount;
    assign w_lsr      = {i_data, 1'b0} >> i_amount;
    assign w_asr      = $signed({i_data, 1'b0}) >>> i_amount;
    assign w_ror      = DATA_W'({i_data, i_data} >> i_amount);
    assign w_amt_zero = (i_amount == '0);

    // Result select: pass-through, immediate-zero specials, or real shift
    always_comb begin
        o_data_c  = i_data;
        o_carry_c = i_carry;
        if (i_exec) begin
            if (w_amt_zero) begin
                // Register amount of zero never shifts; immediate zero
                // encodes #32 for LSR/ASR and RRX for ROR.
                if (!i_use_rs) begin
                    case (i_opcode)
                        SHIFT_LSR: begin
                            o_data_c  = '0;
                            o_carry_c = i_data[DATA_W-1];
                        end
                        SHIFT_ASR: begin
                            o_data_c  = {DATA_W{i_data[DATA_W-1]}};
                            o_carry_c = i_data[DATA_W-1];
                        end
                        SHIFT_ROR: begin
                            o_data_c  = {i_carry, i_data[DATA_W-1:1]};
                            o_carry_c = i_data[0];
                        end
                        default: begin
                            o_data_c  = i_data;
                            o_carry_c = i_carry;
                        end
                    endcase
                end
            end else begin
                case (i_opcode)
                    SHIFT_LSL: begin
                        o_data_c  = w_lsl[DATA_W-1:0];
                        o_carry_c = w_lsl[DATA_W];
                    end
                    SHIFT_LSR: begin
                        o_data_c  = w_lsr[DATA_W:1];
                        o_carry_c = w_lsr[0];
                    end
                    SHIFT_ASR: begin
                        o_data_c  = w_asr[DATA_W:1];
                        o_carry_c = w_asr[0];
                    end
                    default: begin
                        o_data_c  = w_ror;
                        o_carry_c = w_ror[DATA_W-1];
                    end
                endcase
            end
        end
    end

endmodule : arm_shift_core

// File: rtl/arm_shift_cond_unit.sv
// Operand-B pre-processing stage of the ARM ALU pipe: evaluates the
// condition field against NZCV, barrel-shifts operand B, and registers the
// result, execute decision and shifter carry for the ALU (1-cycle latency).
// Ports:
//   clk_in / reset_in                 clock, async active-low reset
//   operand_b_in                      unshifted operand B
//   shift_opcode_in                   00 LSL, 01 LSR, 10 ASR, 11 ROR
//   use_rs_to_shift_in                amount from Rs (1) or immediate (0)
//   shift_from_rs_in / shift_value_in register / immediate shift amount
//   cond_in / flags_in                condition field, NZCV flags
//   carry_in                          shifter carry source
//   shifted_operandB_out              registered shifted operand
//   instr_exec_out                    registered condition-pass flag
//   carry_frm_barrel_shifter_out      registered shifter carry-out
module arm_shift_cond_unit
    import arm_shift_cond_unit_pkg::*;
(
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic [31:0]        operand_b_in,
    input  logic [1:0]         shift_opcode_in,
    input  logic               use_rs_to_shift_in,
    input  logic [4:0]         shift_from_rs_in,
    input  logic [4:0]         shift_value_in,
    input  logic [3:0]         cond_in,
    input  logic [3:0]         flags_in,
    input  logic               carry_in,
    output logic [31:0]        shifted_operandB_out,
    output logic               instr_exec_out,
    output logic               carry_frm_barrel_shifter_out
);

    logic               w_n;
    logic               w_z;
    logic               w_c;
    logic               w_v;
    logic               w_exec;
    logic [SHAMT_W-1:0] w_amount;
    logic [DATA_W-1:0]  w_shift_data;
    logic               w_shift_carry;

    logic [DATA_W-1:0]  r_shifted;
    logic               r_exec;
    logic               r_carry;

    assign w_n = flags_in[FLAG_N];
    assign w_z = flags_in[FLAG_Z];
    assign w_c = flags_in[FLAG_C];
    assign w_v = flags_in[FLAG_V];

    assign w_amount = use_rs_to_shift_in ? shift_from_rs_in : shift_value_in;

    // Condition field decode
    always_comb begin
        w_exec = 1'b0;
        case (cond_in)
            COND_EQ: w_exec = w_z;
            COND_NE: w_exec = !w_z;
            COND_CS: w_exec = w_c;
            COND_CC: w_exec = !w_c;
            COND_MI: w_exec = w_n;
            COND_PL: w_exec = !w_n;
            COND_VS: w_exec = w_v;
            COND_VC: w_exec = !w_v;
            COND_HI: w_exec = w_c && !w_z;
            COND_LS: w_exec = !w_c || w_z;
            COND_GE: w_exec = (w_n == w_v);
            COND_LT: w_exec = (w_n != w_v);
            COND_GT: w_exec = !w_z && (w_n == w_v);
            COND_LE: w_exec = w_z || (w_n != w_v);
            COND_AL: w_exec = 1'b1;
            default: w_exec = 1'b0;
        endcase
    end

    arm_shift_core u_shift_core (
        .i_data    (operand_b_in),
        .i_amount  (w_amount),
        .i_opcode  (shift_opcode_in),
        .i_use_rs  (use_rs_to_shift_in),
        .i_carry   (carry_in),
        .i_exec    (w_exec),
        .o_data_c  (w_shift_data),
        .o_carry_c (w_shift_carry)
    );

    // Output stage: free-running, loads every edge
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_shifted <= '0;
            r_exec    <= 1'b0;
            r_carry   <= 1'b0;
        end else begin
            r_shifted <= w_shift_data;
            r_exec    <= w_exec;
            r_carry   <= w_shift_carry;
        end
    end

    assign shifted_operandB_out         = r_shifted;
    assign instr_exec_out               = r_exec;
    assign carry_frm_barrel_shifter_out = r_carry;

endmodule : arm_shift_cond_unit

// File: tb/tb_arm_shift_cond_unit.sv
// Self-checking bench for arm_shift_cond_unit: directed cases with fixed
// expectations plus randomized traffic against a behavioural model.
module tb_arm_shift_cond_unit;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [31:0] operand_b_in;
    logic [1:0]  shift_opcode_in;
    logic        use_rs_to_shift_in;
    logic [4:0]  shift_from_rs_in;
    logic [4:0]  shift_value_in;
    logic [3:0]  cond_in;
    logic [3:0]  flags_in;
    logic        carry_in;
    logic [31:0] shifted_operandB_out;
    logic        instr_exec_out;
    logic        carry_frm_barrel_shifter_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    arm_shift_cond_unit dut (
        .clk_in                       (clk_in),
        .reset_in                     (reset_in),
        .operand_b_in                 (operand_b_in),
        .shift_opcode_in              (shift_opcode_in),
        .use_rs_to_shift_in           (use_rs_to_shift_in),
        .shift_from_rs_in             (shift_from_rs_in),
        .shift_value_in               (shift_value_in),
        .cond_in                      (cond_in),
        .flags_in                     (flags_in),
        .carry_in                     (carry_in),
        .shifted_operandB_out         (shifted_operandB_out),
        .instr_exec_out               (instr_exec_out),
        .carry_frm_barrel_shifter_out (carry_frm_barrel_shifter_out)
    );

    typedef struct {
        logic [31:0] b;
        logic [1:0]  op;
        logic        rs;
        logic [4:0]  rsamt;
        logic [4:0]  imm;
        logic [3:0]  cond;
        logic [3:0]  flags;
        logic        cin;
        logic [31:0] eo;
        logic        ec;
        logic        ee;
    } dvec_t;

    // Reference: condition pass from the ARM rule table
    function automatic bit ref_cond(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (int'(cond))
            0:  return z;
            1:  return !z;
            2:  return c;
            3:  return !c;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return c && !z;
            9:  return !c || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Reference: shifter + condition on the currently driven inputs
    function automatic void ref_model(output logic [31:0] o, output logic c, output logic e);
        int unsigned n;
        logic [31:0] b;
        b = operand_b_in;
        e = ref_cond(cond_in, flags_in);
        o = b;
        c = carry_in;
        if (!e) return;
        n = use_rs_to_shift_in ? int'(shift_from_rs_in) : int'(shift_value_in);
        if (n == 0) begin
            if (use_rs_to_shift_in || shift_opcode_in == 2'd0) return;
            case (shift_opcode_in)
                2'd1: begin o = 32'h0; c = b[31]; end
                2'd2: begin o = b[31] ? 32'hFFFF_FFFF : 32'h0; c = b[31]; end
                default: begin o = (b >> 1) | ({31'h0, carry_in} << 31); c = b[0]; end
            endcase
        end else begin
            case (shift_opcode_in)
                2'd0: begin o = b << n; c = b[32-n]; end
                2'd1: begin o = b >> n; c = b[n-1]; end
                2'd2: begin o = 32'($signed(b) >>> n); c = b[n-1]; end
                default: begin o = (b >> n) | (b << (32 - n)); c = o[31]; end
            endcase
        end
    endfunction

    task automatic drive_random();
        operand_b_in       = $urandom;
        shift_opcode_in    = 2'($urandom_range(0, 3));
        use_rs_to_shift_in = 1'($urandom_range(0, 1));
        shift_from_rs_in   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        shift_value_in     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        cond_in            = 4'($urandom_range(0, 15));
        flags_in           = 4'($urandom_range(0, 15));
        carry_in           = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        logic [31:0] eo;
        logic ec, ee;
        reset_in = 1'b0;
        drive_random();
        cond_in = 4'hE;
        repeat (3) @(posedge clk_in);
        #1;
        n_vec++;
        if (shifted_operandB_out !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 00000000", shifted_operandB_out); end
        if (instr_exec_out !== 1'b0) begin n_err++; $display("FAIL reset_exec got %b want 0", instr_exec_out); end
        if (carry_frm_barrel_shifter_out !== 1'b0) begin n_err++; $display("FAIL reset_carry got %b want 0", carry_frm_barrel_shifter_out); end
        // First edge after release loads a computed value
        reset_in = 1'b1;
        drive_random();
        operand_b_in = 32'hA5A5_0F0F;
        cond_in = 4'hE;
        ref_model(eo, ec, ee);
        @(posedge clk_in);
        #1;
        n_vec++;
        if (shifted_operandB_out !== eo) begin n_err++; $display("FAIL post_reset_data got %h want %h", shifted_operandB_out, eo); end
        if (instr_exec_out !== ee) begin n_err++; $display("FAIL post_reset_exec got %b want %b", instr_exec_out, ee); end
        if (carry_frm_barrel_shifter_out !== ec) begin n_err++; $display("FAIL post_reset_carry got %b want %b", carry_frm_barrel_shifter_out, ec); end
    endtask

    task automatic test_directed();
        dvec_t v[14];
        v[0]  = '{32'h8000_0001, 2'd0, 1'b0, 5'd0, 5'd1,  4'hE, 4'h0, 1'b0, 32'h0000_0002, 1'b1, 1'b1};
        v[1]  = '{32'h8000_0000, 2'd2, 1'b0, 5'd9, 5'd0,  4'hE, 4'h0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1};
        v[2]  = '{32'h8000_0000, 2'd1, 1'b0, 5'd9, 5'd0,  4'hE, 4'h0, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
        v[3]  = '{32'h0000_0003, 2'd3, 1'b0, 5'd9, 5'd0,  4'hE, 4'h0, 1'b1, 32'h8000_0001, 1'b1, 1'b1};
        v[4]  = '{32'h1234_5678, 2'd1, 1'b1, 5'd0, 5'd7,  4'hE, 4'h0, 1'b1, 32'h1234_5678, 1'b1, 1'b1};
        v[5]  = '{32'h1234_5678, 2'd3, 1'b1, 5'd8, 5'd0,  4'hE, 4'h0, 1'b1, 32'h7812_3456, 1'b0, 1'b1};
        v[6]  = '{32'hF000_0008, 2'd2, 1'b1, 5'd4, 5'd0,  4'hE, 4'h0, 1'b0, 32'hFF00_0000, 1'b1, 1'b1};
        v[7]  = '{32'h0000_000F, 2'd0, 1'b0, 5'd0, 5'd4,  4'h0, 4'h0, 1'b0, 32'h0000_000F, 1'b0, 1'b0};
        v[8]  = '{32'h0000_0001, 2'd0, 1'b0, 5'd0, 5'd31, 4'hC, 4'h9, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        v[9]  = '{32'h0000_0003, 2'd1, 1'b0, 5'd0, 5'd1,  4'hD, 4'h4, 1'b0, 32'h0000_0001, 1'b1, 1'b1};
        v[10] = '{32'hAAAA_5555, 2'd3, 1'b1, 5'd4, 5'd0,  4'hF, 4'h6, 1'b1, 32'hAAAA_5555, 1'b1, 1'b0};
        v[11] = '{32'hDEAD_BEEF, 2'd0, 1'b0, 5'd3, 5'd0,  4'hE, 4'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1};
        v[12] = '{32'h0000_0001, 2'd3, 1'b1, 5'd0, 5'd5,  4'hE, 4'h0, 1'b0, 32'h0000_0001, 1'b0, 1'b1};
        v[13] = '{32'h8000_0000, 2'd1, 1'b1, 5'd31, 5'd0, 4'hE, 4'h0, 1'b1, 32'h0000_0001, 1'b0, 1'b1};
        // Back-to-back: each vector is replaced right after its edge
        for (int i = 0; i < 14; i++) begin
            operand_b_in       = v[i].b;
            shift_opcode_in    = v[i].op;
            use_rs_to_shift_in = v[i].rs;
            shift_from_rs_in   = v[i].rsamt;
            shift_value_in     = v[i].imm;
            cond_in            = v[i].cond;
            flags_in           = v[i].flags;
            carry_in           = v[i].cin;
            @(posedge clk_in);
            #1;
            n_vec++;
            if (shifted_operandB_out !== v[i].eo) begin n_err++; $display("FAIL directed%0d_data got %h want %h", i, shifted_operandB_out, v[i].eo); end
            if (instr_exec_out !== v[i].ee) begin n_err++; $display("FAIL directed%0d_exec got %b want %b", i, instr_exec_out, v[i].ee); end
            if (carry_frm_barrel_shifter_out !== v[i].ec) begin n_err++; $display("FAIL directed%0d_carry got %b want %b", i, carry_frm_barrel_shifter_out, v[i].ec); end
        end
    endtask

    task automatic test_cond_sweep();
        logic [31:0] eo;
        logic ec, ee;
        // Every condition against every flag combination, one per cycle
        for (int cnd = 0; cnd < 16; cnd++) begin
            for (int f = 0; f < 16; f++) begin
                drive_random();
                cond_in  = 4'(cnd);
                flags_in = 4'(f);
                ref_model(eo, ec, ee);
                @(posedge clk_in);
                #1;
                n_vec++;
                if (instr_exec_out !== ee) begin n_err++; $display("FAIL cond%0d_flags%0d_exec got %b want %b", cnd, f, instr_exec_out, ee); end
                if (shifted_operandB_out !== eo) begin n_err++; $display("FAIL cond%0d_flags%0d_data got %h want %h", cnd, f, shifted_operandB_out, eo); end
                if (carry_frm_barrel_shifter_out !== ec) begin n_err++; $display("FAIL cond%0d_flags%0d_carry got %b want %b", cnd, f, carry_frm_barrel_shifter_out, ec); end
            end
        end
    endtask

    task automatic test_random_shifts();
        logic [31:0] eo;
        logic ec, ee;
        for (int i = 0; i < 2000; i++) begin
            drive_random();
            // Bias toward executed instructions so the shifter is exercised
            if ($urandom_range(0, 3) != 0) cond_in = 4'hE;
            ref_model(eo, ec, ee);
            @(posedge clk_in);
            #1;
            n_vec++;
            if (shifted_operandB_out !== eo) begin n_err++; $display("FAIL random%0d_data op=%0d rs=%0d amt=%0d/%0d b=%h got %h want %h", i, shift_opcode_in, use_rs_to_shift_in, shift_from_rs_in, shift_value_in, operand_b_in, shifted_operandB_out, eo); end
            if (instr_exec_out !== ee) begin n_err++; $display("FAIL random%0d_exec got %b want %b", i, instr_exec_out, ee); end
            if (carry_frm_barrel_shifter_out !== ec) begin n_err++; $display("FAIL random%0d_carry got %b want %b", i, carry_frm_barrel_shifter_out, ec); end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] eo;
        logic ec, ee;
        drive_random();
        operand_b_in = 32'hFFFF_0001;
        shift_opcode_in = 2'd0;
        use_rs_to_shift_in = 1'b1;
        shift_from_rs_in = 5'd0;
        cond_in = 4'hE;
        carry_in = 1'b1;
        @(posedge clk_in);
        #2;
        reset_in = 1'b0;
        #1;
        n_vec++;
        if (shifted_operandB_out !== 32'h0) begin n_err++; $display("FAIL async_reset_data got %h want 00000000", shifted_operandB_out); end
        if (instr_exec_out !== 1'b0) begin n_err++; $display("FAIL async_reset_exec got %b want 0", instr_exec_out); end
        if (carry_frm_barrel_shifter_out !== 1'b0) begin n_err++; $display("FAIL async_reset_carry got %b want 0", carry_frm_barrel_shifter_out); end
        @(posedge clk_in);
        #1;
        n_vec++;
        if (shifted_operandB_out !== 32'h0) begin n_err++; $display("FAIL reset_hold_data got %h want 00000000", shifted_operandB_out); end
        reset_in = 1'b1;
        ref_model(eo, ec, ee);
        @(posedge clk_in);
        #1;
        n_vec++;
        if (shifted_operandB_out !== eo) begin n_err++; $display("FAIL release_data got %h want %h", shifted_operandB_out, eo); end
        if (carry_frm_barrel_shifter_out !== ec) begin n_err++; $display("FAIL release_carry got %b want %b", carry_frm_barrel_shifter_out, ec); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_cond_sweep();
        test_random_shifts();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_arm_shift_cond_unit
